// File: rtl/ysyx_24100005_ifu_if.sv
// Bundles the IFU's instruction-memory channels, its core-facing output channel,
// the redirect input and the fault report into one interface.
interface ysyx_24100005_ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output out_valid, out_inst, out_pc,
    input  out_ready,
    input  redirect_valid, redirect_pc,
    output fetch_fault, fault_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  out_valid, out_inst, out_pc,
    output out_ready,
    output redirect_valid, redirect_pc,
    input  fetch_fault, fault_pc
  );
endinterface

// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: owns the fetch PC, fetches one word at a time from imem,
// and hands {inst, pc} to the core; handles redirects, memory errors and timeouts.
//
// state   | meaning
// IDLE    | one cycle after reset release
// REQ     | request presented to imem, waiting for ready
// WAIT    | request accepted, waiting for response (kill = squashed)
// HOLD    | instruction presented to core, waiting for out_ready
// FAULT   | sticky fault, only reset leaves it
module ysyx_24100005_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input logic              clk,
  input logic              rst,
  ysyx_24100005_ifu_if.master bus
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          kill_q, kill_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]   out_inst_q, out_inst_d;
  logic [31:0]   out_pc_q, out_pc_d;
  logic [31:0]   fault_pc_q, fault_pc_d;

  logic redir_bad;

  assign redir_bad = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    wait_cnt_d = wait_cnt_q;
    out_inst_d = out_inst_q;
    out_pc_d   = out_pc_q;
    fault_pc_d = fault_pc_q;

    case (state_q)
      S_IDLE: state_d = S_REQ;

      S_REQ: begin
        if (redir_bad) begin
          state_d    = S_FAULT;
          fault_pc_d = bus.redirect_pc;
        end else begin
          if (bus.redirect_valid) pc_d = bus.redirect_pc;
          // A redirect coinciding with the handshake squashes the request just issued.
          if (bus.imem_req_ready) begin
            state_d    = S_WAIT;
            wait_cnt_d = '0;
            kill_d     = bus.redirect_valid;
          end
        end
      end

      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + CW'(1);
        if (redir_bad) begin
          state_d    = S_FAULT;
          fault_pc_d = bus.redirect_pc;
        end else begin
          if (bus.redirect_valid) pc_d = bus.redirect_pc;
          if (bus.imem_rsp_valid) begin
            if (kill_q || bus.redirect_valid) begin
              state_d = S_REQ;
              kill_d  = 1'b0;
            end else if (bus.imem_rsp_err) begin
              state_d    = S_FAULT;
              fault_pc_d = pc_q;
            end else begin
              state_d    = S_HOLD;
              out_inst_d = bus.imem_rsp_data;
              out_pc_d   = pc_q;
            end
          end else if (wait_cnt_q == CNT_LAST) begin
            state_d    = S_FAULT;
            fault_pc_d = pc_q;
          end else if (bus.redirect_valid) begin
            kill_d = 1'b1;
          end
        end
      end

      S_HOLD: begin
        if (redir_bad) begin
          state_d    = S_FAULT;
          fault_pc_d = bus.redirect_pc;
        end else if (bus.redirect_valid) begin
          state_d = S_REQ;
          pc_d    = bus.redirect_pc;
        end else if (bus.out_ready) begin
          state_d = S_REQ;
          pc_d    = pc_q + 32'd4;
        end
      end

      S_FAULT: state_d = S_FAULT;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      wait_cnt_q <= '0;
      out_inst_q <= '0;
      out_pc_q   <= '0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      wait_cnt_q <= wait_cnt_d;
      out_inst_q <= out_inst_d;
      out_pc_q   <= out_pc_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  // Address is gated so it reads zero outside REQ, including during reset.
  assign bus.imem_req_valid = (state_q == S_REQ);
  assign bus.imem_req_addr  = (state_q == S_REQ) ? pc_q : 32'h0;
  assign bus.out_valid      = (state_q == S_HOLD);
  assign bus.out_inst       = out_inst_q;
  assign bus.out_pc         = out_pc_q;
  assign bus.fetch_fault    = (state_q == S_FAULT);
  assign bus.fault_pc       = fault_pc_q;

endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
// Directed bench for the fetch unit: a linear sequence of stimulus steps with
// hand-computed expectations checked by immediate assertions.
module tb_ysyx_24100005_ifu;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  logic outstanding;

  ysyx_24100005_ifu_if bus ();

  ysyx_24100005_ifu #(
    .RESET_PC(32'h8000_0000),
    .TIMEOUT (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("assertion %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".req_valid"},   {31'h0, bus.imem_req_valid}, 32'h0);
    chk({tag, ".req_addr"},    bus.imem_req_addr,            32'h0);
    chk({tag, ".out_valid"},   {31'h0, bus.out_valid},       32'h0);
    chk({tag, ".out_inst"},    bus.out_inst,                 32'h0);
    chk({tag, ".out_pc"},      bus.out_pc,                   32'h0);
    chk({tag, ".fetch_fault"}, {31'h0, bus.fetch_fault},     32'h0);
    chk({tag, ".fault_pc"},    bus.fault_pc,                 32'h0);
  endtask

  // Memory-side protocol: a response is only legal for an accepted, unanswered request.
  always @(negedge clk) begin
    if (!rst) begin
      outstanding = 1'b0;
    end else begin
      if (bus.imem_rsp_valid) begin
        n_assert++;
        assert (outstanding === 1'b1) else begin
          n_fail++;
          $display("FAIL rsp_protocol: observed outstanding=%b expected 1", outstanding);
          $error("assertion rsp_protocol");
        end
        outstanding = 1'b0;
      end
      if (bus.imem_req_valid && bus.imem_req_ready) outstanding = 1'b1;
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    outstanding = 1'b0;
    rst = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.imem_rsp_err   = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    // Reset state
    #2;
    chk_zero("reset");
    tick();
    tick();
    release_reset();
    #1;
    chk("idle.req_valid", {31'h0, bus.imem_req_valid}, 32'h0);

    // First fetch, 1-cycle memory
    tick();
    chk("req0.valid", {31'h0, bus.imem_req_valid}, 32'h1);
    chk("req0.addr", bus.imem_req_addr, 32'h8000_0000);
    bus.imem_req_ready = 1'b1;
    tick();
    chk("wait0.req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h0000_0013;
    tick();
    bus.imem_rsp_valid = 1'b0;
    chk("hold0.out_valid", {31'h0, bus.out_valid}, 32'h1);
    chk("hold0.out_inst", bus.out_inst, 32'h0000_0013);
    chk("hold0.out_pc", bus.out_pc, 32'h8000_0000);

    // Back-pressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall.out_valid", {31'h0, bus.out_valid}, 32'h1);
      chk("stall.out_inst", bus.out_inst, 32'h0000_0013);
      chk("stall.out_pc", bus.out_pc, 32'h8000_0000);
      chk("stall.req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("req1.addr", bus.imem_req_addr, 32'h8000_0004);
    chk("req1.out_valid", {31'h0, bus.out_valid}, 32'h0);

    // Redirect while waiting; late response must be discarded
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0100;
    tick();
    bus.redirect_valid = 1'b0;
    chk("kill.req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
    tick();
    chk("kill.out_valid", {31'h0, bus.out_valid}, 32'h0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    bus.imem_rsp_valid = 1'b0;
    chk("kill.out_valid2", {31'h0, bus.out_valid}, 32'h0);
    chk("kill.out_inst", bus.out_inst, 32'h0000_0013);
    chk("kill.req_addr", bus.imem_req_addr, 32'h8000_0100);

    // Timeout: no response for 16 WAIT cycles
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("tmo.no_fault_yet", {31'h0, bus.fetch_fault}, 32'h0);
    end
    tick();
    chk("tmo.fault", {31'h0, bus.fetch_fault}, 32'h1);
    chk("tmo.fault_pc", bus.fault_pc, 32'h8000_0100);
    chk("tmo.req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0200;
    tick();
    bus.redirect_valid = 1'b0;
    chk("fault.redir_ignored", bus.fault_pc, 32'h8000_0100);
    chk("fault.sticky", {31'h0, bus.fetch_fault}, 32'h1);

    // Memory error on the second request
    do_reset();
    chk_zero("reset2");
    release_reset();
    tick();
    tick();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h0010_0093;
    tick();
    bus.imem_rsp_valid = 1'b0;
    chk("err.hold_inst", bus.out_inst, 32'h0010_0093);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("err.req_addr", bus.imem_req_addr, 32'h8000_0004);
    tick();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_err   = 1'b1;
    tick();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_err   = 1'b0;
    chk("err.fault", {31'h0, bus.fetch_fault}, 32'h1);
    chk("err.fault_pc", bus.fault_pc, 32'h8000_0004);

    // Misaligned redirect
    do_reset();
    release_reset();
    bus.imem_req_ready = 1'b0;
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0102;
    tick();
    bus.redirect_valid = 1'b0;
    chk("mis.fault", {31'h0, bus.fetch_fault}, 32'h1);
    chk("mis.fault_pc", bus.fault_pc, 32'h8000_0102);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mis.req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
    end

    // PC wrap, redirect at handshake, redirect in HOLD, reset mid-WAIT
    do_reset();
    release_reset();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    chk("wrap.req_valid", {31'h0, bus.imem_req_valid}, 32'h1);
    chk("wrap.req_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h0000_0073;
    tick();
    bus.imem_rsp_valid = 1'b0;
    chk("wrap.out_pc", bus.out_pc, 32'hFFFF_FFFC);
    chk("wrap.out_inst", bus.out_inst, 32'h0000_0073);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("wrap.next_addr", bus.imem_req_addr, 32'h0000_0000);
    chk("wrap.next_valid", {31'h0, bus.imem_req_valid}, 32'h1);

    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0040;
    tick();
    bus.redirect_valid = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h1111_1111;
    bus.imem_rsp_err   = 1'b1;
    tick();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_err   = 1'b0;
    chk("hsredir.no_fault", {31'h0, bus.fetch_fault}, 32'h0);
    chk("hsredir.out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("hsredir.req_addr", bus.imem_req_addr, 32'h8000_0040);

    tick();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h2222_2222;
    tick();
    bus.imem_rsp_valid = 1'b0;
    chk("holdredir.out_pc", bus.out_pc, 32'h8000_0040);
    chk("holdredir.out_inst", bus.out_inst, 32'h2222_2222);
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0080;
    tick();
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    chk("holdredir.req_addr", bus.imem_req_addr, 32'h8000_0080);
    chk("holdredir.out_valid", {31'h0, bus.out_valid}, 32'h0);

    tick();
    chk("midwait.req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
    do_reset();
    chk_zero("midwait_reset");
    bus.imem_req_ready = 1'b0;
    release_reset();
    tick();
    chk("post.req_valid", {31'h0, bus.imem_req_valid}, 32'h1);
    chk("post.req_addr", bus.imem_req_addr, 32'h8000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
